// File: rtl/qam4_frame_mapper.sv
// Byte stream to framed 4QAM symbols for the OTFS modulator, with start pulse and inter-frame gap.
// Define QAM4_SCRAMBLER_EN to XOR each symbol's bits with a PRBS7 (x^7+x^6+1) stream.
module qam4_frame_mapper #(
  parameter int          FRAME_SYMS = 4096,
  parameter int          FRAME_GAP  = 8500,
  parameter logic [11:0] QAM_AMP    = 12'h5A8
) (
  input  logic        Clk,
  input  logic        Srst,
  input  logic        Enable,
  input  logic        BitDataValid,
  input  logic [7:0]  BitData,
  output logic        BitDataReady,
  output logic        Start,
  output logic        QAMDataValid,
  output logic [11:0] QAMDataRe,
  output logic [11:0] QAMDataIm,
  output logic [1:0]  QAMData_instruct,
  output logic        FrameBusy,
  output logic        FrameDone
);
  typedef enum logic [1:0] {IDLE, START, MAP, GAP} state_t;

  localparam logic [11:0] QAM_NEG     = ~QAM_AMP + 12'd1;
  localparam logic [15:0] LAST_SYM    = 16'(FRAME_SYMS - 1);
  localparam logic [15:0] FRAME_BYTES = 16'(FRAME_SYMS / 4);
  localparam logic [15:0] LAST_GAP    = 16'(FRAME_GAP - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] sym_cnt;
  logic [15:0] byte_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  hold;
  logic        full;
  logic [1:0]  pair;
  logic        issue;
  logic        last_sym;
  logic        accept;
  logic [1:0]  raw_bits;
  logic [1:0]  sym_bits;
  logic [1:0]  scr_bits;

`ifdef QAM4_SCRAMBLER_EN
  logic [6:0] lfsr;
  logic [6:0] lfsr_adv;

  // Two LFSR steps per symbol; the bit shifted out first scrambles b[1].
  always_comb begin
    scr_bits = lfsr[6:5];
    lfsr_adv = {lfsr[4:0], lfsr[6] ^ lfsr[5], lfsr[5] ^ lfsr[4]};
  end

  always_ff @(posedge Clk) begin
    if (Srst || state == START) begin
      lfsr <= 7'h7F;
    end else if (issue) begin
      lfsr <= lfsr_adv;
    end
  end
`else
  assign scr_bits = 2'b00;
`endif

  always_comb begin
    issue        = (state == MAP) && full;
    last_sym     = issue && (sym_cnt == LAST_SYM);
    // Take a new byte only when the holding register is free or its last pair leaves now.
    BitDataReady = (state == MAP) && (!full || (pair == 2'd3 && issue)) && (byte_cnt < FRAME_BYTES);
    accept       = BitDataValid && BitDataReady;

    raw_bits = hold[7:6];
    case (pair)
      2'd0:    raw_bits = hold[7:6];
      2'd1:    raw_bits = hold[5:4];
      2'd2:    raw_bits = hold[3:2];
      default: raw_bits = hold[1:0];
    endcase
    sym_bits = raw_bits ^ scr_bits;

    state_next = state;
    case (state)
      IDLE:    if (Enable) state_next = START;
      START:   state_next = MAP;
      MAP:     if (last_sym) state_next = GAP;
      GAP:     if (gap_cnt == LAST_GAP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Srst) begin
      state            <= IDLE;
      sym_cnt          <= 16'd0;
      byte_cnt         <= 16'd0;
      gap_cnt          <= 16'd0;
      hold             <= 8'd0;
      full             <= 1'b0;
      pair             <= 2'd0;
      Start            <= 1'b0;
      QAMDataValid     <= 1'b0;
      QAMDataRe        <= 12'd0;
      QAMDataIm        <= 12'd0;
      QAMData_instruct <= 2'b00;
      FrameBusy        <= 1'b0;
      FrameDone        <= 1'b0;
    end else begin
      state            <= state_next;
      Start            <= (state_next == START);
      FrameBusy        <= (state_next != IDLE);
      QAMDataValid     <= issue;
      FrameDone        <= last_sym;
      QAMDataRe        <= issue ? (sym_bits[1] ? QAM_AMP : QAM_NEG) : 12'd0;
      QAMDataIm        <= issue ? (sym_bits[0] ? QAM_NEG : QAM_AMP) : 12'd0;
      QAMData_instruct <= issue ? sym_bits : 2'b00;

      if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
      else              gap_cnt <= 16'd0;

      if (state == START) begin
        sym_cnt  <= 16'd0;
        byte_cnt <= 16'd0;
        pair     <= 2'd0;
        full     <= 1'b0;
      end

      if (issue) sym_cnt <= sym_cnt + 16'd1;

      if (accept) begin
        hold     <= BitData;
        full     <= 1'b1;
        pair     <= 2'd0;
        byte_cnt <= byte_cnt + 16'd1;
      end else if (issue) begin
        pair <= pair + 2'd1;
        if (pair == 2'd3) full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_qam4_frame_mapper.sv
// Bench for qam4_frame_mapper: fixed symbol table for a 1B stream plus randomized byte streams
// scored against a queue model of the byte slicing, mapping and PRBS7 scrambling.
`timescale 1ns/1ps
module tb_qam4_frame_mapper;
  localparam int          FRAME_SYMS = 4096;
  localparam int          FRAME_GAP  = 8500;
  localparam logic [11:0] AMP_POS    = 12'h5A8;
  localparam logic [11:0] AMP_NEG    = 12'hA58;
`ifdef QAM4_SCRAMBLER_EN
  localparam bit SCRAMBLE = 1'b1;
`else
  localparam bit SCRAMBLE = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Srst;
  logic        Enable;
  logic        BitDataValid;
  logic [7:0]  BitData;
  logic        BitDataReady;
  logic        Start;
  logic        QAMDataValid;
  logic [11:0] QAMDataRe;
  logic [11:0] QAMDataIm;
  logic [1:0]  QAMData_instruct;
  logic        FrameBusy;
  logic        FrameDone;

  qam4_frame_mapper #(
    .FRAME_SYMS(FRAME_SYMS),
    .FRAME_GAP (FRAME_GAP),
    .QAM_AMP   (AMP_POS)
  ) dut (
    .Clk             (Clk),
    .Srst            (Srst),
    .Enable          (Enable),
    .BitDataValid    (BitDataValid),
    .BitData         (BitData),
    .BitDataReady    (BitDataReady),
    .Start           (Start),
    .QAMDataValid    (QAMDataValid),
    .QAMDataRe       (QAMDataRe),
    .QAMDataIm       (QAMDataIm),
    .QAMData_instruct(QAMData_instruct),
    .FrameBusy       (FrameBusy),
    .FrameDone       (FrameDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  instr;
    logic [11:0] re;
    logic [11:0] im;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  bit prbs [2*FRAME_SYMS];

  function automatic logic [1:0] scrOf(input int idx);
    return SCRAMBLE ? {prbs[2*idx], prbs[2*idx+1]} : 2'b00;
  endfunction

  // Scoreboard state, sampled on the falling edge.
  logic [1:0]  exp_q[$];
  int          cyc = 0, sym_idx = 0, bytes_acc = 0, frames_done = 0, starts = 0;
  int          last_syms = 0, last_bytes = 0, start_cyc = 0, done_cyc = 0, fall_cyc = 0, cap_n = 0;
  bit          rst_pend = 1'b1, prev_busy = 1'b0, done_seen = 1'b0, in_gap = 1'b0, cap_en = 1'b0;
  logic [1:0]  cap_instr [8];
  logic [11:0] cap_re [8];
  logic [11:0] cap_im [8];

  always @(negedge Clk) begin
    logic [1:0] raw;
    logic [1:0] expb;
    cyc++;
    if (rst_pend) begin
      checkOutput("outputs_after_reset", 32'({BitDataReady, Start, QAMDataValid, QAMDataRe, QAMDataIm,
                  QAMData_instruct, FrameBusy, FrameDone}), 32'd0);
      exp_q.delete();
      sym_idx   = 0;
      bytes_acc = 0;
      prev_busy = 1'b0;
      done_seen = 1'b0;
      in_gap    = 1'b0;
    end else begin
      if (FrameDone) in_gap = 1'b1;
      if (Start) begin
        checkOutput("start_after_idle", 32'(prev_busy), 32'd0);
        checkOutput("prev_frame_drained", 32'(exp_q.size()), 32'd0);
        if (done_seen) checkOutput("start_gap", 32'((cyc - done_cyc) >= FRAME_GAP + 1), 32'd1);
        exp_q.delete();
        starts++;
        start_cyc = cyc;
        sym_idx   = 0;
        bytes_acc = 0;
        in_gap    = 1'b0;
      end
      if (BitDataReady) checkOutput("ready_only_in_map", 32'(FrameBusy && !Start && !in_gap), 32'd1);
      if (BitDataValid && BitDataReady && !Srst) begin
        exp_q.push_back(BitData[7:6]);
        exp_q.push_back(BitData[5:4]);
        exp_q.push_back(BitData[3:2]);
        exp_q.push_back(BitData[1:0]);
        bytes_acc++;
      end
      if (QAMDataValid) begin
        checkOutput("model_has_symbol", 32'(exp_q.size() > 0), 32'd1);
        raw  = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
        expb = raw ^ scrOf(sym_idx % FRAME_SYMS);
        checkOutput("instruct", 32'(QAMData_instruct), 32'(expb));
        checkOutput("re", 32'(QAMDataRe), 32'(expb[1] ? AMP_POS : AMP_NEG));
        checkOutput("im", 32'(QAMDataIm), 32'(expb[0] ? AMP_NEG : AMP_POS));
        if (sym_idx == 0) checkOutput("first_sym_latency", 32'((cyc - start_cyc) >= 2), 32'd1);
        if (cap_en && cap_n < 8) begin
          cap_instr[cap_n] = QAMData_instruct;
          cap_re[cap_n]    = QAMDataRe;
          cap_im[cap_n]    = QAMDataIm;
          cap_n++;
        end
        sym_idx++;
        checkOutput("framedone_align", 32'(FrameDone), 32'(sym_idx == FRAME_SYMS));
      end else begin
        checkOutput("idle_outputs_zero", 32'({QAMDataRe, QAMDataIm, QAMData_instruct, FrameDone}), 32'd0);
      end
      if (prev_busy && !FrameBusy) fall_cyc = cyc;
      if (FrameDone) begin
        frames_done++;
        last_syms  = sym_idx;
        last_bytes = bytes_acc;
        done_cyc   = cyc;
        done_seen  = 1'b1;
      end
      prev_busy = FrameBusy;
    end
    rst_pend = Srst;
  end

  logic [7:0] cur_byte = 8'h00;
  int         drv_cnt  = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // mode 0: constant byte every cycle; 1: valid one cycle in three; 2: random valid, random bytes
  task automatic applyStimulus(input int mode, input logic [7:0] cbyte);
    bit acc;
    case (mode)
      0:       begin BitDataValid = 1'b1; BitData = cbyte; end
      1:       begin BitDataValid = (drv_cnt % 3 == 0); BitData = cur_byte; end
      default: begin BitDataValid = ($urandom_range(3) != 0); BitData = cur_byte; end
    endcase
    acc = BitDataValid && BitDataReady;
    tick();
    drv_cnt++;
    if (acc) cur_byte = 8'($urandom);
  endtask

  task automatic runFrames(input int mode, input logic [7:0] cbyte, input int target, input int limit);
    int n = 0;
    while (frames_done < target && n < limit) begin
      applyStimulus(mode, cbyte);
      n++;
    end
    checkOutput("frames_reached", 32'(frames_done), 32'(target));
  endtask

  task automatic runUntilSym(input int mode, input logic [7:0] cbyte, input int target, input int limit);
    int n = 0;
    while (sym_idx < target && n < limit) begin
      applyStimulus(mode, cbyte);
      n++;
    end
    checkOutput("symbols_reached", 32'(sym_idx >= target), 32'd1);
  endtask

  task automatic pulseReset();
    Srst         = 1'b1;
    BitDataValid = 1'b0;
    tick();
    Srst = 1'b0;
    tick();
  endtask

  vec_t vecs [8];

  initial begin
    logic [1:0]  tbl_instr [8];
    logic [11:0] pt_re [4];
    logic [11:0] pt_im [4];
    int base;
    int st;
    int n;

    for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
    for (int i = 7; i < 2*FRAME_SYMS; i++) prbs[i] = prbs[i-7] ^ prbs[i-6];

    pt_re = '{12'hA58, 12'hA58, 12'h5A8, 12'h5A8};
    pt_im = '{12'h5A8, 12'hA58, 12'h5A8, 12'hA58};
`ifdef QAM4_SCRAMBLER_EN
    tbl_instr = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b11};
`else
    tbl_instr = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
`endif
    for (int i = 0; i < 8; i++) begin
      vecs[i].data  = 8'h1B;
      vecs[i].instr = tbl_instr[i];
      vecs[i].re    = pt_re[tbl_instr[i]];
      vecs[i].im    = pt_im[tbl_instr[i]];
    end

    Srst = 1'b1; Enable = 1'b0; BitDataValid = 1'b0; BitData = 8'h00;
    repeat (3) tick();
    Srst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 32'({Start, FrameBusy, BitDataReady}), 32'd0);

    // Two back-to-back frames of 8'h1B with Enable held high.
    $display("[TB] two frames, continuous 8'h1B");
    cap_en = 1'b1; cap_n = 0; Enable = 1'b1;
    base = frames_done; st = starts;
    runFrames(0, vecs[0].data, base + 1, 15000);
    checkOutput("f1_symbols", 32'(last_syms), 32'(FRAME_SYMS));
    checkOutput("f1_bytes", 32'(last_bytes), 32'(FRAME_SYMS/4));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("vec%0d_instr", i), 32'(cap_instr[i]), 32'(vecs[i].instr));
      checkOutput($sformatf("vec%0d_re", i), 32'(cap_re[i]), 32'(vecs[i].re));
      checkOutput($sformatf("vec%0d_im", i), 32'(cap_im[i]), 32'(vecs[i].im));
    end
    cap_en = 1'b0;
    runFrames(0, vecs[0].data, base + 2, 16000);
    checkOutput("f2_symbols", 32'(last_syms), 32'(FRAME_SYMS));
    checkOutput("two_starts", 32'(starts), 32'(st + 2));

    // Sparse source: valid one cycle in three, random bytes.
    $display("[TB] sparse source");
    Enable = 1'b0;
    pulseReset();
    Enable = 1'b1;
    base = frames_done;
    runFrames(1, 8'h00, base + 1, 15000);
    checkOutput("sparse_symbols", 32'(last_syms), 32'(FRAME_SYMS));
    checkOutput("sparse_bytes", 32'(last_bytes), 32'(FRAME_SYMS/4));

    // Reset mid-frame with random stalls, then a clean restart.
    $display("[TB] reset at symbol 2000");
    Enable = 1'b0;
    pulseReset();
    Enable = 1'b1;
    st = starts;
    runUntilSym(2, 8'h00, 2000, 8000);
    Srst = 1'b1;
    BitDataValid = 1'b0;
    tick();
    checkOutput("srst_mid_frame", 32'({Start, QAMDataValid, QAMDataRe, QAMDataIm, QAMData_instruct,
                FrameBusy, FrameDone}), 32'd0);
    Srst = 1'b0;
    base = frames_done;
    runFrames(2, 8'h00, base + 1, 12000);
    checkOutput("restart_symbols", 32'(last_syms), 32'(FRAME_SYMS));
    checkOutput("restart_start_count", 32'(starts), 32'(st + 2));

    // Enable dropped at symbol 100: frame completes, gap runs out, no new Start.
    $display("[TB] enable drop at symbol 100");
    Enable = 1'b0;
    pulseReset();
    cap_en = 1'b1; cap_n = 0; Enable = 1'b1;
    base = frames_done; st = starts;
    runUntilSym(0, 8'h00, 100, 300);
    Enable = 1'b0;
    runFrames(0, 8'h00, base + 1, 6000);
    checkOutput("drop_symbols", 32'(last_syms), 32'(FRAME_SYMS));
    n = 0;
    while (FrameBusy && n < FRAME_GAP + 20) begin
      applyStimulus(0, 8'h00);
      n++;
    end
    tick();
    checkOutput("busy_fell", 32'(FrameBusy), 32'd0);
    checkOutput("gap_length", 32'(fall_cyc - done_cyc), 32'(FRAME_GAP));
    repeat (20) applyStimulus(0, 8'h00);
    checkOutput("no_restart", 32'(starts), 32'(st + 1));
    checkOutput("first_instr_zero_bytes", 32'(cap_instr[0]), 32'(SCRAMBLE ? 2'b11 : 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
